seq_gen_1011: RTL and testbench



---
 rtl/seq_gen_1011.sv | 141 ++++++++++++++
 tb/tb_seq_gen_1011.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_1011.sv
// Serial pattern transmitter: sends PATTERN MSB-first, cmd_reps times, with cmd_gap idle zeros between repetitions.
// Latency: first pattern bit one cycle after the accepting edge; done pulses the cycle after the last bit.
// Backpressure: none downstream; cmd_ready is high only in IDLE, so one command is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  command offered; accepted when cmd_ready is also high
//   cmd_ready  high only in IDLE
//   cmd_reps   number of pattern repetitions (0 = empty command, done only)
//   cmd_gap    zero-bit cycles between repetitions
//   abort      synchronous cancel; ignored in IDLE
//   out_bit    serial data, forced to 0 whenever out_valid is 0
//   out_valid  out_bit carries a pattern bit this cycle
//   busy       any state other than IDLE
//   done       one-cycle pulse on normal completion
module seq_gen_1011 #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 4,
  parameter int                   GAP_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_reps,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PATTERN_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  logic [GAP_W-1:0] gap_reg, gap_reg_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rep_cnt <= '0;
      gap_reg <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      rep_cnt <= rep_cnt_n;
      gap_reg <= gap_reg_n;
      gap_cnt <= gap_cnt_n;
      bit_idx <= bit_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    rep_cnt_n = rep_cnt;
    gap_reg_n = gap_reg;
    gap_cnt_n = gap_cnt;
    bit_idx_n = bit_idx;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rep_cnt_n = cmd_reps;
          gap_reg_n = cmd_gap;
          bit_idx_n = IDX_LAST;
          state_n   = (cmd_reps == '0) ? DONE : SEND;
        end
      end

      SEND: begin
        if (bit_idx == '0) begin
          // End of one repetition: count it and pick what follows.
          rep_cnt_n = rep_cnt - CNT_W'(1);
          bit_idx_n = IDX_LAST;
          if (rep_cnt == CNT_W'(1)) begin
            state_n = DONE;
          end else if (gap_reg == '0) begin
            state_n = SEND;
          end else begin
            state_n   = GAP;
            gap_cnt_n = gap_reg;
          end
        end else begin
          bit_idx_n = bit_idx - IDX_W'(1);
        end
      end

      GAP: begin
        // bit_idx was already reloaded on entry to GAP.
        gap_cnt_n = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) begin
          state_n = SEND;
        end
      end

      DONE: begin
        state_n   = IDLE;
        rep_cnt_n = '0;
        gap_reg_n = '0;
        gap_cnt_n = '0;
        bit_idx_n = '0;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Cancel wins over everything except the IDLE accept path.
    if (abort && (state != IDLE)) begin
      state_n   = IDLE;
      rep_cnt_n = '0;
      gap_reg_n = '0;
      gap_cnt_n = '0;
      bit_idx_n = '0;
    end
  end

  // Outputs decode from registered state only; no input reaches an output.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == SEND);
  assign out_bit   = (state == SEND) && PATTERN[bit_idx];

endmodule

// File: tb/tb_seq_gen_1011.sv
module tb_seq_gen_1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_reps;
  logic [2:0] cmd_gap;
  logic       abort;
  logic       out_bit;
  logic       out_valid;
  logic       busy;
  logic       done;

  seq_gen_1011 dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_reps  (cmd_reps),
    .cmd_gap   (cmd_gap),
    .abort     (abort),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Expected output vector per cycle: {cmd_ready, busy, done, out_valid, out_bit}
  localparam logic [4:0] E_IDLE = 5'b10000;
  localparam logic [4:0] E_DONE = 5'b01100;
  localparam logic [4:0] E_GAP  = 5'b01000;

  logic [3:0] pat_bits = 4'b1011;
  logic [4:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         acc_cnt  = 0;

  function automatic logic [4:0] obs_vec();
    return {cmd_ready, busy, done, out_valid, out_bit};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Push the expected cycle-by-cycle output stream for one command.
  // cut >= 0 keeps only the first cut active cycles (abort/reset cases) and
  // then expects IDLE outputs with no done pulse.
  task automatic push_stream(input int reps, input int gap, input int cut);
    int n = 0;
    for (int r = 0; r < reps; r++) begin
      for (int b = 3; b >= 0; b--) begin
        if (cut < 0 || n < cut) sb_q.push_back({4'b0101, pat_bits[b]});
        n++;
      end
      if (r < reps - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (cut < 0 || n < cut) sb_q.push_back(E_GAP);
          n++;
        end
      end
    end
    if (cut < 0) sb_q.push_back(E_DONE);
    sb_q.push_back(E_IDLE);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
    end while (sb_q.size() != 0 && cyc < 300);
    if (sb_q.size() != 0) begin
      chk("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    #1;
  endtask

  task automatic run_cmd(input int reps, input int gap);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_reps  = 4'(reps);
    cmd_gap   = 3'(gap);
    @(posedge clk);
    push_stream(reps, gap, -1);
    #1 cmd_valid = 1'b0;
    wait_drain();
  endtask

  // Monitor: compare one scoreboard entry per cycle, mid-cycle.
  always @(negedge clk) begin
    chk("ready_and_busy", {31'd0, cmd_ready & busy}, 0);
    if (reset && cmd_valid && cmd_ready) acc_cnt++;
    if (sb_q.size() != 0) begin
      logic [4:0] e;
      e = sb_q.pop_front();
      chk("out_vec", obs_vec(), e);
    end
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_reps  = '0;
    cmd_gap   = '0;
    abort     = 1'b0;
    #1 chk("reset_outputs", obs_vec(), E_IDLE);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single repetition, back-to-back timing.
    run_cmd(1, 0);
    // Two repetitions with a two-cycle gap.
    run_cmd(2, 2);
    // Empty command: done only.
    run_cmd(0, 3);
    // Gap of one and several back-to-back repetitions.
    run_cmd(3, 1);
    run_cmd(2, 0);
    run_cmd(2, 7);

    // Abort in the second GAP cycle, then a new command on the following edge.
    cmd_valid = 1'b1;
    cmd_reps  = 4'd3;
    cmd_gap   = 3'd3;
    @(posedge clk);
    push_stream(3, 3, 6);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    run_cmd(1, 0);

    // Asynchronous reset mid-SEND after 6 bits.
    cmd_valid = 1'b1;
    cmd_reps  = 4'd4;
    cmd_gap   = 3'd0;
    @(posedge clk);
    push_stream(4, 0, 6);
    #1 cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("async_reset", obs_vec(), E_IDLE);
    cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_held", obs_vec(), E_IDLE);
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1 chk("reset_release", obs_vec(), E_IDLE);
    if (sb_q.size() != 0) chk("reset_sb_left", sb_q.size(), 0);
    sb_q.delete();
    run_cmd(1, 0);

    // cmd_valid held high: three commands accepted every 6 cycles.
    acc_cnt   = 0;
    cmd_valid = 1'b1;
    cmd_reps  = 4'd1;
    cmd_gap   = 3'd5;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      push_stream(1, 5, -1);
      if (k < 2) repeat (5) @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    wait_drain();
    chk("held_accepts", acc_cnt, 3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
